// File: rtl/gm_fifo_downsizer.sv
// gm_fifo_downsizer: register-based FWFT FIFO that stores wide words and emits them
// as RATIO narrow slices, LSB slice first, over a valid/ready handshake.
module gm_fifo_downsizer #(
  parameter int DEPTH     = 8,
  parameter int WIDTH_IN  = 128,
  parameter int WIDTH_OUT = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_wr_en,
  input  logic [WIDTH_IN-1:0]        i_data_in,
  output logic                       o_full,
  output logic                       o_wr_err,
  output logic [WIDTH_OUT-1:0]       o_data_out,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int RATIO = WIDTH_IN / WIDTH_OUT;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(RATIO);
  localparam int CW    = AW + 1;

  logic [WIDTH_IN-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]       r_lane;
  logic [CW-1:0]       r_count;
  logic                r_wr_err;
  logic                w_full, w_valid, w_wr, w_pop, w_last;

  assign w_full      = r_count == CW'(DEPTH);
  assign w_valid     = r_count != '0;
  assign w_wr        = i_wr_en && !w_full;
  assign w_pop       = w_valid && i_out_ready;
  assign w_last      = w_pop && r_lane == LW'(RATIO - 1);
  assign o_full      = w_full;
  assign o_out_valid = w_valid;
  assign o_count     = r_count;
  assign o_wr_err    = r_wr_err;
  assign o_data_out  = r_mem[r_rd_ptr][r_lane*WIDTH_OUT +: WIDTH_OUT];

  // Storage is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lane   <= '0;
      r_count  <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && w_full;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_lane <= w_last ? '0 : r_lane + 1'b1;
      if (w_last) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_last);
    end
  end
endmodule

// File: tb/tb_gm_fifo_downsizer.sv
// tb_gm_fifo_downsizer: directed plus random stimulus checked against a queue-of-words
// model that tracks the head word and the slice currently being offered.
module tb_gm_fifo_downsizer;
  localparam int D  = 8;
  localparam int WI = 128;
  localparam int WO = 32;
  localparam int R  = WI / WO;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          out_ready = 1'b0;
  logic [WI-1:0] data_in = '0;
  logic          full, wr_err, out_valid;
  logic [WO-1:0] data_out;
  logic [3:0]    count;

  logic [WI-1:0] q[$];
  logic [WI-1:0] hw;
  int            lane;
  logic          e_err;
  int            checks = 0;
  int            errors = 0;

  gm_fifo_downsizer #(.DEPTH(D), .WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_data_in(data_in),
    .o_full(full), .o_wr_err(wr_err), .o_data_out(data_out),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WI-1:0] obs, input logic [WI-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", WI'(out_valid), WI'(q.size() != 0));
    chk("count", WI'(count), WI'(q.size()));
    chk("full", WI'(full), WI'(q.size() == D));
    chk("wr_err", WI'(wr_err), WI'(e_err));
    if (q.size() != 0) begin
      hw = q[0];
      chk("data_out", WI'(data_out), WI'(hw[lane*WO +: WO]));
    end
  endtask

  // Checks the current outputs, applies one cycle of inputs, advances the model.
  task automatic step(input logic w, input logic [WI-1:0] d, input logic r);
    bit was_full, pop;
    check_all();
    wr_en = w; data_in = d; out_ready = r;
    was_full = q.size() == D;
    pop = q.size() != 0 && r;
    e_err = w && was_full;
    if (pop) begin
      if (lane == R - 1) begin
        lane = 0;
        void'(q.pop_front());
      end else lane++;
    end
    if (w && !was_full) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 48 && q.size() != 0; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
  endtask

  function automatic logic [WI-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [WO-1:0] exp1 [R];

  initial begin
    exp1 = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    lane = 0; e_err = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", WI'(out_valid), '0);
    chk("rst_count", WI'(count), '0);
    chk("rst_full", WI'(full), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, LSB slice first, one-cycle write-to-valid latency
    step(1'b1, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 1'b1);
    for (int i = 0; i < R; i++) begin
      chk("t1_slice", WI'(data_out), WI'(exp1[i]));
      step(1'b0, '0, 1'b1);
    end
    chk("t1_empty_valid", WI'(out_valid), '0);
    chk("t1_empty_count", WI'(count), '0);

    // fill, overflow write, drain in order
    for (int i = 0; i < D; i++) step(1'b1, WI'(i), 1'b0);
    step(1'b1, WI'(99), 1'b0);
    chk("t2_wr_err", WI'(wr_err), 1);
    chk("t2_full", WI'(full), 1);
    step(1'b0, '0, 1'b0);
    chk("t2_err_pulse", WI'(wr_err), '0);
    drain();

    // backpressure mid-word
    step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, (i % 4 == 0) || (i % 4 == 3));
    drain();

    // simultaneous write and final pop with count=3, lane=3
    for (int i = 0; i < 3; i++) step(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, rnd(), 1'b1);
    chk("t4_count", WI'(count), 3);
    drain();

    // simultaneous write and final pop while full
    for (int i = 0; i < D; i++) step(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, rnd(), 1'b1);
    chk("t5_count", WI'(count), 7);
    chk("t5_wr_err", WI'(wr_err), 1);
    drain();

    // 20 writes against a continuous reader, wrapping the pointers
    for (int i = 0; i < 80; i++) step(i % 4 == 0, rnd(), 1'b1);
    drain();

    // reset mid-drain at lane 2
    step(1'b1, rnd(), 1'b0);
    step(1'b1, rnd(), 1'b1);
    step(1'b0, '0, 1'b1);
    wr_en = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t7_async_valid", WI'(out_valid), '0);
    chk("t7_async_count", WI'(count), '0);
    q.delete(); lane = 0; e_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1);
    step(1'b1, 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA, 1'b0);
    chk("t7_slice0", WI'(data_out), WI'(32'hAAAA_AAAA));
    drain();

    // random traffic
    for (int i = 0; i < 600; i++) step($urandom_range(2) == 0, rnd(), $urandom_range(1) == 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gm_fifo_downsizer.md
Name: gm_fifo_downsizer

Overview:
- Single-clock buffering FIFO that narrows the data path. It accepts WIDTH_IN-bit words and delivers them as WIDTH_IN/WIDTH_OUT consecutive WIDTH_OUT-bit slices over a valid/ready handshake.
- It is the wide-to-narrow counterpart of the narrow-to-wide BRAM-backed dual-clock FIFO storage in the NoC path.
- It sits on the NoC ejection side, feeding narrow flits to local consumers.
- Storage is register-based, with first-word fall-through on the output.

Parameters:
- DEPTH, 8, number of WIDTH_IN entries; power of 2, minimum 2.
- WIDTH_IN, 128, write word width.
- WIDTH_OUT, 32, read slice width; WIDTH_IN must be an integer multiple of WIDTH_OUT, ratio ≥ 2.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- data_in  in  WIDTH_IN  write word.
- full  out  1  asserted when count == DEPTH.
- wr_err  out  1  one-cycle pulse: write attempted while full.
- data_out  out  WIDTH_OUT  current slice.
- out_valid  out  1  data_out holds a valid slice.
- out_ready  in  1  consumer accepts the slice.
- count  out  $clog2(DEPTH)+1  number of wide entries held, including a partially drained head.

Behaviour:
- RATIO = WIDTH_IN/WIDTH_OUT.
- State:
  - wr_ptr and rd_ptr, $clog2(DEPTH) bits each, wrap naturally.
  - lane, $clog2(RATIO) bits.
  - count.
  - mem[DEPTH].
- Reset (rst=0, asynchronous): wr_ptr=rd_ptr=lane=count=0, wr_err=0. Outputs are then full=0, out_valid=0. data_out is don't-care but must not be X-dependent on control. mem is not reset.
- Write:
  - Accepted when wr_en && !full. On the edge, mem[wr_ptr] <= data_in and wr_ptr++.
  - wr_en && full drops the data, leaves state unchanged and pulses wr_err high for exactly the next cycle.
  - full is evaluated from the registered count. A write while full is dropped even if a final-slice pop occurs in the same cycle.
- Read:
  - out_valid = (count != 0), combinational from registers.
  - data_out = mem[rd_ptr][lane*WIDTH_OUT +: WIDTH_OUT]. Slices are delivered LSB first.
  - A pop occurs when out_valid && out_ready.
  - On a pop with lane < RATIO-1: lane++.
  - On a pop with lane == RATIO-1: lane <= 0, rd_ptr++, count--.
  - out_ready while !out_valid has no effect.
- Count update:
  - Accepted write with no final pop: +1.
  - Final pop with no accepted write: -1.
  - Both in the same cycle: unchanged.
  - Non-final pops never change count.
- Latency: a write into an empty FIFO gives out_valid=1 in the cycle after the write edge, with slice 0 of that word on data_out. A full-throughput consumer drains one wide word per RATIO cycles.
- Stall: with out_valid=1 and out_ready=0, data_out and lane hold stable indefinitely.
- Wrap-around: the pointers wrap DEPTH-1 → 0 with no bubble. Ordering is strictly FIFO across the wrap.
- Reset mid-drain: all state, including a partially consumed head, is discarded. After rst deasserts, out_valid=0 and no stale slice is ever presented.
- Storage bypass: none. A word written into an empty FIFO is never visible on data_out in the same cycle.

Test Plan:
- Reset, then one write of 128'h4444_4444_3333_3333_2222_2222_1111_1111 with out_ready held 1 → out_valid rises 1 cycle after the write. data_out is 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444 on 4 consecutive cycles. Then out_valid=0 and count=0.
- With out_ready=0, write 8 words 0..7 → full=1 and count=8. A 9th write pulses wr_err for 1 cycle, and the stored data is unchanged. Draining gives words 0..7 in order, 32 slices total.
- Backpressure: toggle out_ready 1,0,0,1,... mid-word → data_out and lane stay stable during stalls. No slice is duplicated or skipped.
- Simultaneous: count=3 and lane=3, with a write and a pop in the same cycle → count stays 3, rd_ptr advances, lane=0.
- Simultaneous at full: count=8, write plus final pop → write dropped, wr_err=1, count=7.
- Wrap: 20 writes interleaved with continuous reads (pointers wrap twice) → the output stream matches the reference model exactly.
- Reset mid-drain: assert rst at lane=2 → out_valid=0 and count=0 immediately (asynchronously). After release, a new write yields its slice 0 first.
